serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor, the sequential successor of the team's combinational half adder. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It then presents Sum, Carry and signed Overflow with a one-cycle done pulse. It sits in the lab datapath wherever area matters more than latency, and with WIDTH=1 and sub=0 it reproduces the half-adder truth table.

---
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Results are registered and held until the next operation completes.
//
// state | meaning
// IDLE  | waiting for start, previous result held
// RUN   | one operand bit per clock through the full-adder cell
// DONE  | one-cycle done pulse, result just updated
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] s_msb;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s;
    logic             c_next;
    logic             last;

    assign s          = op_a[0] ^ op_b[0] ^ c;
    assign c_next     = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);
    assign s_msb      = WIDTH'(s) << (WIDTH - 1);
    assign shreg_next = (shreg >> 1) | s_msb;
    assign last       = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            shreg    <= '0;
            cnt      <= '0;
            c        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        op_a  <= A;
                        op_b  <= sub ? ~B : B;
                        c     <= sub;
                        cnt   <= '0;
                        shreg <= '0;
                    end
                end
                RUN: begin
                    c     <= c_next;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    shreg <= shreg_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // On the MSB bit the pre-update c is the carry into the MSB.
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        Sum      <= shreg_next;
                        Carry    <= c_next;
                        Overflow <= c ^ c_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8, 1 and 16 against an
// arithmetic reference model, plus hand-computed literal vectors.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic st8 = 0, sb8 = 0, bz8, dn8, c8, v8;
    logic [7:0] a8 = 0, b8 = 0, s8;
    logic st1 = 0, sb1 = 0, bz1, dn1, c1, v1;
    logic [0:0] a1 = 0, b1 = 0, s1;
    logic st16 = 0, sb16 = 0, bz16, dn16, c16, v16;
    logic [15:0] a16 = 0, b16 = 0, s16;

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8),
        .A(a8), .B(b8), .busy(bz8), .done(dn8), .Sum(s8), .Carry(c8), .Overflow(v8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1),
        .A(a1), .B(b1), .busy(bz1), .done(dn1), .Sum(s1), .Carry(c1), .Overflow(v1));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .start(st16), .sub(sb16),
        .A(a16), .B(b16), .busy(bz16), .done(dn16), .Sum(s16), .Carry(c16), .Overflow(v16));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        busy;
        logic        done;
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
        int          left;
        logic [63:0] p_sum;
        logic        p_c;
        logic        p_v;
    } mdl_t;

    mdl_t m8, m1, m16;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.busy = 0; n.done = 0; n.sum = '0; n.carry = 0; n.ovf = 0;
        n.left = 0; n.p_sum = '0; n.p_c = 0; n.p_v = 0;
        return n;
    endfunction

    // One clock of the reference: accept, count down WIDTH clocks, publish, idle.
    function automatic mdl_t step(input mdl_t m, input int w, input logic st, input logic sb,
                                  input logic [63:0] a, input logic [63:0] b);
        mdl_t n;
        logic [63:0] mask, aa, bb, r;
        logic sa, sr, sbv;
        n = m;
        n.done = 1'b0;
        if (!m.done && m.busy) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.busy  = 1'b0;
                n.done  = 1'b1;
                n.sum   = m.p_sum;
                n.carry = m.p_c;
                n.ovf   = m.p_v;
            end
        end else if (!m.done && !m.busy && st) begin
            mask = (64'd1 << w) - 64'd1;
            aa = a & mask;
            bb = b & mask;
            if (sb) begin
                r = aa - bb;
                n.p_c = (aa >= bb);
            end else begin
                r = aa + bb;
                n.p_c = r[w];
            end
            n.p_sum = r & mask;
            sa  = aa[w-1];
            sbv = bb[w-1];
            sr  = n.p_sum[w-1];
            n.p_v = sb ? ((sa != sbv) && (sr != sa)) : ((sa == sbv) && (sr != sa));
            n.busy = 1'b1;
            n.left = w;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8  <= mdl_reset();
            m1  <= mdl_reset();
            m16 <= mdl_reset();
        end else begin
            m8  <= step(m8, 8, st8, sb8, 64'(a8), 64'(b8));
            m1  <= step(m1, 1, st1, sb1, 64'(a1), 64'(b1));
            m16 <= step(m16, 16, st16, sb16, 64'(a16), 64'(b16));
        end
    end

    task automatic cmp(input string name, input logic bz, input logic dn, input logic [63:0] s,
                       input logic c, input logic v, input mdl_t m);
        checks++;
        if (bz !== m.busy || dn !== m.done || s !== m.sum || c !== m.carry || v !== m.ovf) begin
            errors++;
            $display("FAIL %s cycle t=%0t: got busy=%b done=%b sum=%h c=%b v=%b, expected busy=%b done=%b sum=%h c=%b v=%b",
                     name, $time, bz, dn, s, c, v, m.busy, m.done, m.sum, m.carry, m.ovf);
        end
    endtask

    always @(negedge clk) begin
        cmp("w8", bz8, dn8, 64'(s8), c8, v8, m8);
        cmp("w1", bz1, dn1, 64'(s1), c1, v1, m1);
        cmp("w16", bz16, dn16, 64'(s16), c16, v16, m16);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int width_of(input int which);
        return which;
    endfunction

    function automatic logic get_done(input int which);
        case (which)
            8:       return dn8;
            1:       return dn1;
            default: return dn16;
        endcase
    endfunction

    function automatic logic [65:0] get_res(input int which);
        case (which)
            8:       return {v8, c8, 64'(s8)};
            1:       return {v1, c1, 64'(s1)};
            default: return {v16, c16, 64'(s16)};
        endcase
    endfunction

    task automatic drive(input int which, input logic st, input logic sb,
                         input logic [63:0] a, input logic [63:0] b);
        case (which)
            8:       begin st8 = st; sb8 = sb; a8 = a[7:0]; b8 = b[7:0]; end
            1:       begin st1 = st; sb1 = sb; a1 = a[0:0]; b1 = b[0:0]; end
            default: begin st16 = st; sb16 = sb; a16 = a[15:0]; b16 = b[15:0]; end
        endcase
    endtask

    // Launch one operation, scramble inputs after accept, check latency and optional literals.
    task automatic run_op(input int which, input logic [63:0] a, input logic [63:0] b,
                          input logic sb, input logic lit, input logic [63:0] es,
                          input logic ec, input logic ev, input string name);
        int cyc;
        logic seen;
        logic [65:0] res;
        @(negedge clk);
        drive(which, 1'b1, sb, a, b);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1)
                drive(which, 1'b0, 1'($urandom), 64'($urandom), 64'($urandom));
            if (get_done(which)) seen = 1'b1;
        end
        checks++;
        if (!seen || (cyc - 1) != width_of(which)) begin
            errors++;
            $display("FAIL %s latency: got %0d clocks (seen=%b), expected %0d",
                     name, cyc - 1, seen, width_of(which));
        end
        if (lit) begin
            res = get_res(which);
            chk({name, " sum"}, res[63:0], es);
            chk({name, " carry"}, 64'(res[64]), 64'(ec));
            chk({name, " ovf"}, 64'(res[65]), 64'(ev));
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int ndone, last_done, gaps_bad;
        logic [65:0] res;
        repeat (3) @(negedge clk);
        chk("reset sum8", 64'(s8), 64'h0);
        chk("reset flags8", 64'({bz8, dn8, c8, v8}), 64'h0);
        rst_n = 1'b1;

        run_op(8, 64'hFF, 64'h01, 1'b0, 1'b1, 64'h00, 1'b1, 1'b0, "add ff+01");
        run_op(8, 64'h7F, 64'h01, 1'b0, 1'b1, 64'h80, 1'b0, 1'b1, "add 7f+01");
        run_op(8, 64'h05, 64'h07, 1'b1, 1'b1, 64'hFE, 1'b0, 1'b0, "sub 05-07");
        run_op(8, 64'h80, 64'h01, 1'b1, 1'b1, 64'h7F, 1'b1, 1'b1, "sub 80-01");

        // Reset in the middle of RUN, while bit 3 is in the cell.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 64'h55, 64'h22);
        @(posedge clk);
        #1 drive(8, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        res = get_res(8);
        chk("async reset sum", res[63:0], 64'h0);
        chk("async reset flags", 64'({bz8, dn8, res[65:64]}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dn8) ndone++;
        end
        chk("no done after reset", 64'(ndone), 64'h0);
        run_op(8, 64'h12, 64'h34, 1'b0, 1'b1, 64'h46, 1'b0, 1'b0, "add 12+34");

        // Start held high with operands changing every clock.
        @(negedge clk);
        drive(8, 1'b1, 1'($urandom), 64'($urandom), 64'($urandom));
        ndone = 0;
        last_done = 0;
        gaps_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (dn8) begin
                if (ndone == 0 ? (k != 9) : (k - last_done != 10)) gaps_bad++;
                ndone++;
                last_done = k;
            end
            drive(8, (k < 40), 1'($urandom), 64'($urandom), 64'($urandom));
        end
        chk("held start done count", 64'(ndone), 64'd4);
        chk("held start spacing", 64'(gaps_bad), 64'd0);
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            run_op(1, 64'(k >> 1), 64'(k & 1), 1'b0, 1'b1, 64'((k >> 1) ^ (k & 1)),
                   1'((k >> 1) & k & 1), 1'((k >> 1) & k & 1), "half adder");
        end
        for (int k = 0; k < 8; k++)
            run_op(1, 64'($urandom), 64'($urandom), 1'($urandom), 1'b0, 64'h0, 1'b0, 1'b0, "w1 rand");

        for (int k = 0; k < 1000; k++) begin
            run_op(16, 64'($urandom), 64'($urandom), 1'($urandom), 1'b0, 64'h0, 1'b0, 1'b0, "w16 rand");
            if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
